serial_rx_controller: RTL and testbench
=======================================

Name: serial_rx_controller

Overview:
- Sequences the serial-to-parallel receive path: detects start bit, times mid-bit sampling from an oversampled clock, strobes the external shift register, checks stop bit, and hands a completed byte to the CPU over a valid/ack handshake.
- Sits between the serial line, the spSR-style shift register and the CPU interface.
- Replaces ad-hoc enable/reset generation with a single clocked FSM.

Parameters:
OVERSAMPLE, 16, clk cycles per serial bit (even, >=4)
DATA_BITS, 8, data bits per frame, LSB first

Ports:
clk  input  1  oversample clock, rising edge
reset  input  1  asynchronous, active-low reset
fromSerial  input  1  raw serial line, idle high
srData  input  DATA_BITS  parallel output of external shift register
cpuAck  input  1  one-cycle pulse: CPU consumed dataToCPU
errClear  input  1  one-cycle pulse: clear sticky error flags
bitStrobe  output  1  one-cycle pulse at data-bit mid-point; shift register samples line this cycle
srClear  output  1  one-cycle pulse clearing shift register before data bits
dataToCPU  output  DATA_BITS  holding register
charReceived  output  1  holding register valid
busy  output  1  frame in progress (state != IDLE)
framingErr  output  1  sticky: stop bit sampled low
overrun  output  1  sticky: frame completed while holding register full

Behaviour:
- Reset (reset=0, async): state IDLE, all counters 0, sync flops 1, dataToCPU 0, charReceived/bitStrobe/srClear/busy/framingErr/overrun 0.
- Input: 2-FF synchronizer; all timing below uses synchronized line rxs (2-cycle latency from fromSerial).
- tick counter: counts 0..OVERSAMPLE-1 within a state; cleared on every state change.
- IDLE: rxs==0 -> START.
- START: when count==OVERSAMPLE/2-1 (mid start bit): rxs==1 -> IDLE (glitch, no flags); rxs==0 -> DATA, srClear=1 for that cycle, bitIdx=0.
- DATA: when count==OVERSAMPLE-1: bitStrobe=1 one cycle, bitIdx++; after DATA_BITS-th strobe -> STOP (or PARITY if enabled).
- STOP: when count==OVERSAMPLE-1: rxs==1 -> deliver (below), -> IDLE; rxs==0 -> framingErr=1, byte discarded, -> BREAK.
- BREAK: wait rxs==1, then -> IDLE (no re-arm on held-low line).
- Deliver: srData is sampled the cycle after last bitStrobe or later; shift register contents are stable during STOP.
  - charReceived==0: dataToCPU<=srData, charReceived<=1 next cycle.
  - charReceived==1 and no cpuAck same cycle: overrun<=1, dataToCPU unchanged.
  - cpuAck same cycle as deliver: new byte loaded, charReceived stays 1, no overrun.
- cpuAck with no deliver: charReceived<=0 next cycle; dataToCPU retained. cpuAck while charReceived==0 ignored.
- errClear: clears framingErr/overrun next cycle; a same-cycle set wins over clear.
- Reset mid-frame: immediate return to IDLE, partial frame lost, outputs as reset.
- bitStrobe and srClear never asserted outside DATA/START transition respectively; never both in one cycle.
- Frame length: start-bit detect to deliver = OVERSAMPLE/2 + (DATA_BITS+1)*OVERSAMPLE cycles (+OVERSAMPLE with parity).

Optional Feature:
- Macro SERIAL_RX_PARITY_EN.
- Defined: PARITY state between DATA and STOP; at count==OVERSAMPLE-1 samples rxs; even parity over srData plus parity bit. Mismatch sets sticky output parityErr (1 bit, reset 0, cleared by errClear) and byte is discarded at STOP (no deliver, no overrun). Port parityErr exists only when defined.
- Undefined: DATA -> STOP directly; no parityErr port.

Test Plan:
- OVERSAMPLE=16, send 0xA5 LSB-first, stop=1 -> exactly 8 bitStrobe pulses 16 cycles apart, one srClear; charReceived=1, dataToCPU=0xA5, framingErr=0.
- fromSerial low for 4 cycles then high -> START aborts at mid-bit, no bitStrobe, returns IDLE, busy low, no flags.
- Frame 0x3C with stop=0, line held low 40 cycles -> framingErr=1, charReceived unchanged, no re-arm until line high; next valid 0x11 received correctly.
- Two frames 0x01, 0x02 without cpuAck -> dataToCPU=0x01, overrun=1; cpuAck on deliver cycle of a third frame 0x03 -> dataToCPU=0x03, charReceived=1, overrun not set again.
- reset asserted during DATA bit 4 -> all outputs 0 asynchronously; subsequent frame 0x5A received correctly.
- With SERIAL_RX_PARITY_EN, 0x07 with parity bit 0 -> parityErr=1, no deliver; with parity bit 1 -> dataToCPU=0x07, parityErr=0.

Source files
------------

// File: rtl/serial_rx_controller.sv
// serial_rx_controller
//   Receive sequencer for an oversampled UART-style serial line. It finds the
//   start bit, times mid-bit sampling, strobes/clears the external shift
//   register, checks the stop bit and hands each byte to the CPU through a
//   valid/ack holding register with sticky error flags.
//
//   Optional feature macro: SERIAL_RX_PARITY_EN (even parity bit after data,
//   adds the parityErr port).
//
//   Ports
//     clk          oversample clock, rising edge
//     reset        asynchronous active-low reset
//     fromSerial   raw serial line, idle high
//     srData       parallel output of the external shift register
//     cpuAck       CPU consumed dataToCPU (one-cycle pulse)
//     errClear     clear sticky error flags (one-cycle pulse)
//     bitStrobe    shift register samples the line this cycle
//     srClear      clear the shift register before the data bits
//     dataToCPU    holding register
//     charReceived holding register valid
//     busy         frame in progress
//     framingErr   sticky: stop bit sampled low
//     overrun      sticky: frame completed while holding register full
//     parityErr    sticky: parity mismatch (SERIAL_RX_PARITY_EN only)
module serial_rx_controller #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fromSerial,
  input  logic [DATA_BITS-1:0] srData,
  input  logic                 cpuAck,
  input  logic                 errClear,
  output logic                 bitStrobe,
  output logic                 srClear,
  output logic [DATA_BITS-1:0] dataToCPU,
  output logic                 charReceived,
  output logic                 busy,
  output logic                 framingErr,
  output logic                 overrun
`ifdef SERIAL_RX_PARITY_EN
  ,
  output logic                 parityErr
`endif
);

  localparam int unsigned CNT_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(OVERSAMPLE - 2);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_e;

  state_e                 state_q;
  logic                   rx_meta_q;
  logic                   rxs_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [IDX_W-1:0]       bit_idx_q;
  logic                   bit_strobe_q;
  logic                   sr_clear_q;
  logic [DATA_BITS-1:0]   data_q;
  logic                   char_q;
  logic                   busy_q;
  logic                   framing_err_q;
  logic                   overrun_q;
`ifdef SERIAL_RX_PARITY_EN
  logic                   parity_err_q;
  logic                   par_bad_q;
`endif

  // Receive sequencer, line synchronizer and CPU holding register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      rx_meta_q     <= 1'b1;
      rxs_q         <= 1'b1;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      bit_strobe_q  <= 1'b0;
      sr_clear_q    <= 1'b0;
      data_q        <= '0;
      char_q        <= 1'b0;
      busy_q        <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parity_err_q  <= 1'b0;
      par_bad_q     <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= fromSerial;
      rxs_q        <= rx_meta_q;
      bit_strobe_q <= 1'b0;
      sr_clear_q   <= 1'b0;
      cnt_q        <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);

      // Clears are written first so a same-cycle set below takes priority.
      if (errClear) begin
        framing_err_q <= 1'b0;
        overrun_q     <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        parity_err_q  <= 1'b0;
`endif
      end
      if (cpuAck && char_q) begin
        char_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rxs_q) begin
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end

        // Re-check the line at mid start bit to reject glitches.
        START: begin
          if (cnt_q == CNT_MID) begin
            cnt_q <= '0;
            if (rxs_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q    <= DATA;
              sr_clear_q <= 1'b1;
              bit_idx_q  <= '0;
`ifdef SERIAL_RX_PARITY_EN
              par_bad_q  <= 1'b0;
`endif
            end
          end
        end

        // Strobe is registered one count early so it lands on the last count.
        DATA: begin
          if (cnt_q == CNT_PRE) begin
            bit_strobe_q <= 1'b1;
          end
          if (cnt_q == CNT_LAST) begin
            bit_idx_q <= bit_idx_q + IDX_W'(1);
            if (bit_idx_q == IDX_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end
        end

`ifdef SERIAL_RX_PARITY_EN
        // Even parity: data bits plus parity bit must XOR to zero.
        PARITY: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= STOP;
            if (^{srData, rxs_q}) begin
              parity_err_q <= 1'b1;
              par_bad_q    <= 1'b1;
            end
          end
        end
`endif

        STOP: begin
          if (cnt_q == CNT_LAST) begin
            if (rxs_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
              if (!par_bad_q) begin
`else
              begin
`endif
                if (!char_q || cpuAck) begin
                  data_q <= srData;
                  char_q <= 1'b1;
                end else begin
                  overrun_q <= 1'b1;
                end
              end
            end else begin
              framing_err_q <= 1'b1;
              state_q       <= BREAK;
            end
          end
        end

        // Held-low line must return high before a new start is accepted.
        BREAK: begin
          cnt_q <= '0;
          if (rxs_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bitStrobe    = bit_strobe_q;
  assign srClear      = sr_clear_q;
  assign dataToCPU    = data_q;
  assign charReceived = char_q;
  assign busy         = busy_q;
  assign framingErr   = framing_err_q;
  assign overrun      = overrun_q;
`ifdef SERIAL_RX_PARITY_EN
  assign parityErr    = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_rx_controller.sv
// tb_serial_rx_controller
//   Scoreboard bench for serial_rx_controller: frames are driven on the raw
//   line, an external shift register is modelled here, expected bytes are
//   queued when a frame that should deliver is sent and popped on delivery.
module tb_serial_rx_controller;

  localparam int OS = 16;
  localparam int DB = 8;
`ifdef SERIAL_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // Line edge to deliver: 2 sync + 1 detect + half bit + data/parity/stop bits.
  localparam int LAT     = 3 + OS / 2 + (DB + 1 + PB) * OS;
  localparam int ACK_OFS = LAT - 1 - OS * (1 + DB + PB);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          fromSerial = 1'b1;
  logic [DB-1:0] srData;
  logic          cpuAck = 1'b0;
  logic          errClear = 1'b0;
  logic          bitStrobe;
  logic          srClear;
  logic [DB-1:0] dataToCPU;
  logic          charReceived;
  logic          busy;
  logic          framingErr;
  logic          overrun;
`ifdef SERIAL_RX_PARITY_EN
  logic          parityErr;
`endif

  serial_rx_controller #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk          (clk),
    .reset        (reset),
    .fromSerial   (fromSerial),
    .srData       (srData),
    .cpuAck       (cpuAck),
    .errClear     (errClear),
    .bitStrobe    (bitStrobe),
    .srClear      (srClear),
    .dataToCPU    (dataToCPU),
    .charReceived (charReceived),
    .busy         (busy),
    .framingErr   (framingErr),
    .overrun      (overrun)
`ifdef SERIAL_RX_PARITY_EN
    ,
    .parityErr    (parityErr)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // External shift register: LSB arrives first, shifts in from the top.
  logic [DB-1:0] sr_q = '0;
  always @(posedge clk) begin
    if (srClear)        sr_q <= '0;
    else if (bitStrobe) sr_q <= {fromSerial, sr_q[DB-1:1]};
  end
  assign srData = sr_q;

  // Monitor: strobe bookkeeping and delivery detection for the scoreboard.
  int strobe_cnt = 0;
  int clr_cnt = 0;
  int spacing_err = 0;
  int last_strobe = -1;
  int deliver_cyc = 0;
  logic          prev_char = 1'b0;
  logic [DB-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (reset) begin
      if (bitStrobe && srClear) chk("strobe_clear_excl", 32'({bitStrobe, srClear}), 32'h2);
      if (srClear) begin
        clr_cnt++;
        last_strobe = -1;
      end
      if (bitStrobe) begin
        if (last_strobe >= 0 && (cyc - last_strobe) != OS) spacing_err++;
        last_strobe = cyc;
        strobe_cnt++;
      end
      if (charReceived && (!prev_char || dataToCPU != prev_data)) begin
        deliver_cyc = cyc;
        if (exp_q.size() == 0) chk("sb_unexpected", 32'(exp_q.size()), 1);
        else                   chk("sb_data", 32'(dataToCPU), 32'(exp_q.pop_front()));
      end
    end
    prev_char = charReceived;
    prev_data = dataToCPU;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    cpuAck = 1'b1;
    @(negedge clk);
    cpuAck = 1'b0;
  endtask

  task automatic pulse_clr();
    errClear = 1'b1;
    @(negedge clk);
    errClear = 1'b0;
  endtask

  // Drives one full frame starting at a falling clock edge.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic ack_on_deliver, input logic par_flip);
    start_cyc = cyc;
    fromSerial = 1'b0;
    idle(OS);
    for (int i = 0; i < DB; i++) begin
      fromSerial = d[i];
      idle(OS);
    end
    if (PB != 0) begin
      fromSerial = (^d) ^ par_flip;
      idle(OS);
    end
    fromSerial = stop_bit;
    if (ack_on_deliver) begin
      idle(ACK_OFS);
      pulse_ack();
      idle(OS - ACK_OFS - 1);
    end else begin
      idle(OS);
    end
  endtask

  int s0;
  int c0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    chk("rst_char", 32'(charReceived), 0);
    chk("rst_data", 32'(dataToCPU), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", 32'({framingErr, overrun, bitStrobe, srClear}), 0);
    reset = 1'b1;
    idle(5);

    // Basic frame 0xA5.
    s0 = strobe_cnt; c0 = clr_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    idle(4);
    chk("a5_strobes", 32'(strobe_cnt - s0), 8);
    chk("a5_srclear", 32'(clr_cnt - c0), 1);
    chk("a5_spacing", 32'(spacing_err), 0);
    chk("a5_char", 32'(charReceived), 1);
    chk("a5_data", 32'(dataToCPU), 32'hA5);
    chk("a5_ferr", 32'(framingErr), 0);
    chk("a5_latency", 32'(deliver_cyc - start_cyc), 32'(LAT));
    chk("a5_busy", 32'(busy), 0);
    pulse_ack();
    idle(1);
    chk("ack_char", 32'(charReceived), 0);
    chk("ack_data_kept", 32'(dataToCPU), 32'hA5);

    // Short glitch: start aborts at mid-bit.
    s0 = strobe_cnt; c0 = clr_cnt;
    fromSerial = 1'b0;
    idle(4);
    fromSerial = 1'b1;
    idle(2);
    chk("glitch_busy_start", 32'(busy), 1);
    idle(24);
    chk("glitch_busy_end", 32'(busy), 0);
    chk("glitch_strobes", 32'(strobe_cnt - s0 + clr_cnt - c0), 0);
    chk("glitch_flags", 32'({framingErr, overrun, charReceived}), 0);

    // Framing error with the line held low, then recovery.
    s0 = strobe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    idle(40);
    chk("brk_ferr", 32'(framingErr), 1);
    chk("brk_char", 32'(charReceived), 0);
    chk("brk_busy", 32'(busy), 1);
    fromSerial = 1'b1;
    idle(20);
    chk("brk_rearm", 32'(strobe_cnt - s0), 8);
    chk("brk_idle", 32'(busy), 0);
    pulse_clr();
    idle(1);
    chk("ferr_clear", 32'(framingErr), 0);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    idle(4);
    chk("rx11_data", 32'(dataToCPU), 32'h11);
    chk("rx11_ferr", 32'(framingErr), 0);
    pulse_ack();
    idle(4);

    // Overrun, then ack on the deliver cycle.
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 1'b0, 1'b0);
    idle(4);
    send_frame(8'h02, 1'b1, 1'b0, 1'b0);
    idle(4);
    chk("ovr_data", 32'(dataToCPU), 32'h01);
    chk("ovr_flag", 32'(overrun), 1);
    chk("ovr_char", 32'(charReceived), 1);
    pulse_clr();
    idle(1);
    chk("ovr_clear", 32'(overrun), 0);
    exp_q.push_back(8'h03);
    send_frame(8'h03, 1'b1, 1'b1, 1'b0);
    idle(4);
    chk("ackdel_data", 32'(dataToCPU), 32'h03);
    chk("ackdel_char", 32'(charReceived), 1);
    chk("ackdel_ovr", 32'(overrun), 0);

    // Reset during data bit 4.
    fromSerial = 1'b0;
    idle(OS);
    for (int i = 0; i < 4; i++) begin
      fromSerial = i[0];
      idle(OS);
    end
    fromSerial = 1'b1;
    idle(8);
    chk("pre_rst_busy", 32'(busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_char", 32'(charReceived), 0);
    chk("arst_data", 32'(dataToCPU), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_flags", 32'({framingErr, overrun, bitStrobe, srClear}), 0);
    idle(3);
    reset = 1'b1;
    idle(5);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    idle(4);
    chk("rx5a_data", 32'(dataToCPU), 32'h5A);
    chk("rx5a_char", 32'(charReceived), 1);
    pulse_ack();
    idle(4);

`ifdef SERIAL_RX_PARITY_EN
    // 0x07 has odd weight: parity bit 0 is wrong, 1 is right.
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    idle(4);
    chk("par_bad_flag", 32'(parityErr), 1);
    chk("par_bad_char", 32'(charReceived), 0);
    chk("par_bad_ovr", 32'(overrun), 0);
    pulse_clr();
    idle(1);
    chk("par_clear", 32'(parityErr), 0);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    idle(4);
    chk("par_ok_data", 32'(dataToCPU), 32'h07);
    chk("par_ok_flag", 32'(parityErr), 0);
    pulse_ack();
    idle(4);
`endif

    idle(20);
    chk("sb_empty", 32'(exp_q.size()), 0);
    chk("strobe_spacing", 32'(spacing_err), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
